// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 arcade keyboard input block: scan codes,
// receiver FSM states, INP0/INP1 bit positions and the key lookup.
// PS2_P2_MIRROR_EN: when defined, player-2 controls mirror player 1.
package ps2_pkg;

  localparam logic [7:0] ScExt    = 8'hE0;
  localparam logic [7:0] ScBrk    = 8'hF0;
  localparam logic [7:0] ScUp     = 8'h75;  // E0-prefixed
  localparam logic [7:0] ScDown   = 8'h72;  // E0-prefixed
  localparam logic [7:0] ScLeft   = 8'h6B;  // E0-prefixed
  localparam logic [7:0] ScRight  = 8'h74;  // E0-prefixed
  localparam logic [7:0] ScSpace  = 8'h29;
  localparam logic [7:0] ScKey1   = 8'h16;
  localparam logic [7:0] ScKey2   = 8'h1E;
  localparam logic [7:0] ScKey5   = 8'h2E;
  localparam logic [7:0] ScKey6   = 8'h36;
  localparam logic [7:0] ScF1     = 8'h05;
  localparam logic [7:0] ScF3     = 8'h04;
  localparam logic [7:0] ScW      = 8'h1D;
  localparam logic [7:0] ScS      = 8'h1B;
  localparam logic [7:0] ScA      = 8'h1C;
  localparam logic [7:0] ScD      = 8'h23;
  localparam logic [7:0] ScLShift = 8'h12;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  localparam int unsigned Inp0Pump1   = 0;
  localparam int unsigned Inp0Pump2   = 1;
  localparam int unsigned Inp0Start1  = 2;
  localparam int unsigned Inp0Start2  = 3;
  localparam int unsigned Inp0Coin1   = 4;
  localparam int unsigned Inp0Coin2   = 5;
  localparam int unsigned Inp0Service = 7;

  localparam int unsigned Inp1Up1    = 0;
  localparam int unsigned Inp1Right1 = 1;
  localparam int unsigned Inp1Down1  = 2;
  localparam int unsigned Inp1Left1  = 3;
  localparam int unsigned Inp1Up2    = 4;
  localparam int unsigned Inp1Right2 = 5;
  localparam int unsigned Inp1Down2  = 6;
  localparam int unsigned Inp1Left2  = 7;

  // Key vector layout: [7:0] INP0, [15:8] INP1, [16] reset request
  localparam int unsigned KeyInp1Base = 8;
  localparam int unsigned KeyReset    = 16;
  localparam int unsigned KeyW        = 17;

  // One-hot (or zero for unmapped) key-vector mask for a scan code
  function automatic logic [KeyW-1:0] key_mask(input logic ext, input logic [7:0] code);
    logic [KeyW-1:0] m;
    m = '0;
    if (ext) begin
      case (code)
        ScUp:    m[KeyInp1Base + Inp1Up1]    = 1'b1;
        ScDown:  m[KeyInp1Base + Inp1Down1]  = 1'b1;
        ScLeft:  m[KeyInp1Base + Inp1Left1]  = 1'b1;
        ScRight: m[KeyInp1Base + Inp1Right1] = 1'b1;
        default: ;
      endcase
    end else begin
      case (code)
        ScSpace:  m[Inp0Pump1]   = 1'b1;
        ScKey1:   m[Inp0Start1]  = 1'b1;
        ScKey2:   m[Inp0Start2]  = 1'b1;
        ScKey5:   m[Inp0Coin1]   = 1'b1;
        ScKey6:   m[Inp0Coin2]   = 1'b1;
        ScF1:     m[Inp0Service] = 1'b1;
        ScF3:     m[KeyReset]    = 1'b1;
`ifndef PS2_P2_MIRROR_EN
        ScW:      m[KeyInp1Base + Inp1Up2]    = 1'b1;
        ScS:      m[KeyInp1Base + Inp1Down2]  = 1'b1;
        ScA:      m[KeyInp1Base + Inp1Left2]  = 1'b1;
        ScD:      m[KeyInp1Base + Inp1Right2] = 1'b1;
        ScLShift: m[Inp0Pump2]                = 1'b1;
`endif
        default: ;
      endcase
    end
`ifdef PS2_P2_MIRROR_EN
    // Single keyboard: every player-1 key also drives the player-2 bit
    m[Inp0Pump2] = m[Inp0Pump1];
    m[KeyInp1Base + Inp1Up2 +: 4] = m[KeyInp1Base + Inp1Up1 +: 4];
`endif
    return m;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pad synchronizers, clock glitch
// filter, 11-bit frame FSM with odd parity check and inactivity timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 8,
  parameter int unsigned TIMEOUT_CYC = 96000
) (
  input  logic       clk_48M,
  input  logic       nRESET,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       code_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int unsigned FiltW = $clog2(FILT_LEN + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);

  logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             filt_q, filt_prev_q;
  logic             fall;
  rx_state_e        state_q;
  logic [2:0]       bitcnt_q;
  logic [7:0]       shift_q;
  logic             par_q;
  logic [TmoW-1:0]  tmo_q;

  // Two-stage synchronizers, reset to the bus-idle level
  always_ff @(posedge clk_48M) begin
    if (!nRESET) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: follow the clock only after FILT_LEN differing samples in a row
  always_ff @(posedge clk_48M) begin
    if (!nRESET) begin
      filt_cnt_q  <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_s2_q == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FiltW'(FILT_LEN - 1)) begin
        filt_cnt_q <= '0;
        filt_q     <= clk_s2_q;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  // Frame FSM with timeout; edge handling takes priority so strobes never coincide
  always_ff @(posedge clk_48M) begin
    if (!nRESET) begin
      state_q    <= StIdle;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      code_valid <= 1'b0;
      scan_code  <= '0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall || state_q == StIdle) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (fall) begin
        unique case (state_q)
          StIdle: begin
            if (!dat_s2_q) begin
              state_q  <= StData;
              bitcnt_q <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          StData: begin
            shift_q <= {dat_s2_q, shift_q[7:1]};
            if (bitcnt_q == 3'd7) begin
              state_q <= StParity;
            end
            bitcnt_q <= bitcnt_q + 1'b1;
          end
          StParity: begin
            par_q   <= dat_s2_q;
            state_q <= StStop;
          end
          StStop: begin
            if (dat_s2_q && (^{par_q, shift_q})) begin
              code_valid <= 1'b1;
              scan_code  <= shift_q;
            end else begin
              frame_err <= 1'b1;
            end
            state_q <= StIdle;
          end
        endcase
      end else if (state_q != StIdle && tmo_q == TmoW'(TIMEOUT_CYC)) begin
        state_q   <= StIdle;
        shift_q   <= '0;
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_arcade_input.sv
// PS/2 keyboard to arcade control bytes: receives scan codes and keeps a
// held-key register for INP0, INP1 and the reset request.
// PS2_P2_MIRROR_EN: when defined, player-2 bits copy player 1.
module ps2_arcade_input
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 8,
  parameter int unsigned TIMEOUT_CYC = 96000
) (
  input  logic       clk_48M,
  input  logic       nRESET,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] INP0,
  output logic [7:0] INP1,
  output logic       resetKey,
  output logic       code_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  logic [KeyW-1:0] keys_q;
  logic [KeyW-1:0] mask;
  logic            ext_q, brk_q;

  ps2_frame_rx #(
    .FILT_LEN    (FILT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk_48M    (clk_48M),
    .nRESET     (nRESET),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code_valid (code_valid),
    .scan_code  (scan_code),
    .frame_err  (frame_err)
  );

  assign mask = key_mask(ext_q, scan_code);

  // Prefix tracking and make/break application; a bad frame drops pending prefixes
  always_ff @(posedge clk_48M) begin
    if (!nRESET) begin
      keys_q <= '0;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
    end else if (frame_err) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (code_valid) begin
      if (scan_code == ScExt) begin
        ext_q <= 1'b1;
      end else if (scan_code == ScBrk) begin
        brk_q <= 1'b1;
      end else begin
        keys_q <= brk_q ? (keys_q & ~mask) : (keys_q | mask);
        ext_q  <= 1'b0;
        brk_q  <= 1'b0;
      end
    end
  end

  // INP0[6] has no mapping, so it is never set
  assign INP0     = keys_q[7:0];
  assign INP1     = keys_q[15:8];
  assign resetKey = keys_q[KeyReset];

endmodule

// File: tb/tb_ps2_arcade_input.sv
// Scoreboard bench for ps2_arcade_input: directed PS/2 frames, expected
// strobes and key bytes queued by the stimulus, checked by a monitor.
module tb_ps2_arcade_input;

`ifdef PS2_P2_MIRROR_EN
  localparam bit Mir = 1'b1;
`else
  localparam bit Mir = 1'b0;
`endif
  localparam int unsigned FiltLen = 8;
  localparam int unsigned TmoCyc  = 2000;
  localparam int          Half    = 30;

  logic       clk_48M = 1'b0;
  logic       nRESET  = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] INP0, INP1, scan_code;
  logic       resetKey, code_valid, frame_err;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    logic [7:0] i0;
    logic [7:0] i1;
    logic       rk;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_fe_seen = 0;
  int   fe_cyc = 0;
  int   last_fall_cyc = 0;

  ps2_arcade_input #(
    .FILT_LEN    (FiltLen),
    .TIMEOUT_CYC (TmoCyc)
  ) dut (
    .clk_48M    (clk_48M),
    .nRESET     (nRESET),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .INP0       (INP0),
    .INP1       (INP1),
    .resetKey   (resetKey),
    .code_valid (code_valid),
    .scan_code  (scan_code),
    .frame_err  (frame_err)
  );

  always #5 clk_48M = ~clk_48M;
  always @(posedge clk_48M) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic exp_code(input logic [7:0] c, input logic [7:0] i0, input logic [7:0] i1,
                          input logic rk);
    exp_t e;
    e.is_err = 1'b0; e.code = c; e.i0 = i0; e.i1 = i1; e.rk = rk;
    exp_q.push_back(e);
  endtask

  task automatic exp_err(input logic [7:0] i0, input logic [7:0] i1, input logic rk);
    exp_t e;
    e.is_err = 1'b1; e.code = 8'h00; e.i0 = i0; e.i1 = i1; e.rk = rk;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_48M);
  endtask

  // Send the first nbits of a frame; optional parity flip and clock glitches
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits,
                           input bit glitch);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (glitch) begin
        wait_cyc(10); ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(Half - 13);
      end else begin
        wait_cyc(Half);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (glitch) begin
        wait_cyc(10); ps2_clk = 1'b1; wait_cyc(3); ps2_clk = 1'b0; wait_cyc(Half - 13);
      end else begin
        wait_cyc(Half);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(2 * Half);
  endtask

  task automatic send_code(input logic [7:0] b, input logic [7:0] i0, input logic [7:0] i1,
                           input logic rk);
    exp_code(b, i0, i1, rk);
    send_bits(b, 1'b0, 11, 1'b0);
  endtask

  // Monitor: pop the expected event on each strobe, check key bytes one cycle later
  initial begin : monitor
    exp_t       e;
    logic       got_err;
    logic [7:0] got_code;
    forever begin
      @(negedge clk_48M);
      if (code_valid || frame_err) begin
        check("strobes_exclusive", {31'd0, code_valid & frame_err}, 32'd0);
        got_err  = frame_err;
        got_code = scan_code;
        if (frame_err) begin
          n_fe_seen++;
          fe_cyc = cyc;
        end
        @(negedge clk_48M);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got err=%0b code=0x%0h want none", got_err, got_code);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_is_err", {31'd0, got_err}, {31'd0, e.is_err});
          if (!e.is_err) check("scan_code", {24'd0, got_code}, {24'd0, e.code});
          check("INP0", {24'd0, INP0}, {24'd0, e.i0});
          check("INP1", {24'd0, INP1}, {24'd0, e.i1});
          check("resetKey", {31'd0, resetKey}, {31'd0, e.rk});
        end
      end
    end
  end

  initial begin : stim
    int seen;
    int waited;
    wait_cyc(4);
    check("rst_INP0", {24'd0, INP0}, 32'd0);
    check("rst_INP1", {24'd0, INP1}, 32'd0);
    check("rst_resetKey", {31'd0, resetKey}, 32'd0);
    check("rst_scan_code", {24'd0, scan_code}, 32'd0);
    check("rst_strobes", {30'd0, code_valid, frame_err}, 32'd0);
    nRESET = 1'b1;
    wait_cyc(20);

    // Space make/break
    send_code(8'h29, Mir ? 8'h03 : 8'h01, 8'h00, 1'b0);
    send_code(8'hF0, Mir ? 8'h03 : 8'h01, 8'h00, 1'b0);
    send_code(8'h29, 8'h00, 8'h00, 1'b0);

    // Extended up arrow, then bare 75 (unmapped)
    send_code(8'hE0, 8'h00, 8'h00, 1'b0);
    send_code(8'h75, 8'h00, Mir ? 8'h11 : 8'h01, 1'b0);
    send_code(8'h75, 8'h00, Mir ? 8'h11 : 8'h01, 1'b0);

    // Break prefix then a parity error: next 2E must be a make
    send_code(8'hF0, 8'h00, Mir ? 8'h11 : 8'h01, 1'b0);
    exp_err(8'h00, Mir ? 8'h11 : 8'h01, 1'b0);
    send_bits(8'h2E, 1'b1, 11, 1'b0);
    send_code(8'h2E, 8'h10, Mir ? 8'h11 : 8'h01, 1'b0);
    send_code(8'hF0, 8'h10, Mir ? 8'h11 : 8'h01, 1'b0);
    send_code(8'h2E, 8'h00, Mir ? 8'h11 : 8'h01, 1'b0);

    // Stall after 5 bits: timeout abort
    exp_err(8'h00, Mir ? 8'h11 : 8'h01, 1'b0);
    seen = n_fe_seen;
    send_bits(8'h16, 1'b0, 5, 1'b0);
    waited = 0;
    while (n_fe_seen == seen && waited < TmoCyc + 500) begin
      wait_cyc(1);
      waited++;
    end
    if (n_fe_seen == seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_seen: got no frame_err want frame_err within %0d cycles", waited);
    end else begin
      n_cmp++;
      if (fe_cyc - last_fall_cyc < int'(TmoCyc) || fe_cyc - last_fall_cyc > int'(TmoCyc) + 30) begin
        n_bad++;
        $display("FAIL timeout_latency: got %0d cycles want %0d..%0d", fe_cyc - last_fall_cyc,
                 TmoCyc, TmoCyc + 30);
      end
    end
    wait_cyc(10);
    send_code(8'h16, 8'h04, Mir ? 8'h11 : 8'h01, 1'b0);

    // F3 with clock glitches, then release
    exp_code(8'h04, 8'h04, Mir ? 8'h11 : 8'h01, 1'b1);
    send_bits(8'h04, 1'b0, 11, 1'b1);
    send_code(8'hF0, 8'h04, Mir ? 8'h11 : 8'h01, 1'b1);
    send_code(8'h04, 8'h04, Mir ? 8'h11 : 8'h01, 1'b0);

    // Player-2 keys
    send_code(8'h1D, 8'h04, 8'h11, 1'b0);
    send_code(8'h12, Mir ? 8'h04 : 8'h06, 8'h11, 1'b0);

    // Reset mid-frame
    send_bits(8'h36, 1'b0, 4, 1'b0);
    nRESET = 1'b0;
    wait_cyc(1);
    nRESET = 1'b1;
    check("midrst_INP0", {24'd0, INP0}, 32'd0);
    check("midrst_INP1", {24'd0, INP1}, 32'd0);
    check("midrst_resetKey", {31'd0, resetKey}, 32'd0);
    check("midrst_scan_code", {24'd0, scan_code}, 32'd0);
    wait_cyc(4 * Half);
    send_code(8'h36, 8'h20, 8'h00, 1'b0);

    wait_cyc(50);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
